mant_align_acc: RTL
===================

# mant_align_acc

Block-floating-point mantissa aligner and accumulator for the GEMM datapath. Sits directly downstream of `exp_normalizer`. Each beat, it takes four sign/mantissa lanes plus that stage's `max_exp` and per-lane `exp_offset_num`. It right-aligns each lane to the shared exponent, sums the four lanes into a signed partial, and accumulates partials across beats until `in_last`. It then presents one `{acc_man, acc_exp}` result over a valid/ready handshake.

## Interface
- `expWidth`, 3: exponent field width; must match `exp_normalizer`.
- `manWidth`, 4: lane mantissa width, hidden bit included (MSB).
- `guardBits`, 3: extra LSBs appended before alignment; aligned lane width `AW = manWidth+guardBits`.
- `accWidth`, 16: signed accumulator width; must be ≥ AW+3.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: beat present.
- `in_ready`, out, 1: beat accepted when `in_valid & in_ready`.
- `in_last`, in, 1: beat is the final beat of a dot product.
- `in_sign`, in, 4: per-lane sign; bit i belongs to lane i.
- `in_man`, in, 4*manWidth: lane i mantissa at `[i*manWidth +: manWidth]`.
- `max_exp`, in, expWidth: shared exponent of the beat.
- `exp_offset_num`, in, 4*expWidth: lane i right-shift at `[i*expWidth +: expWidth]`.
- `out_valid`, out, 1: result held.
- `out_ready`, in, 1: consumer accepts.
- `acc_man`, out, accWidth: signed two's-complement accumulated mantissa.
- `acc_exp`, out, expWidth: exponent of `acc_man`. LSB weight is 2^(acc_exp−(manWidth−1)−guardBits).

## Operation
- **S1, align:** per lane, `mag = {in_man, guardBits'b0} >> offset`.
  - Offset ≥ AW gives 0.
  - Signed lane = `in_sign ? −mag : mag`, AW+1 bits.
  - `max_exp` and `in_last` are registered alongside the lane values.
- **S2, sum:** sign-extend the four lanes to AW+3 and add them; register the partial, its exponent `e_b`, and its last flag.
- **S3, accumulate FSM:** states EMPTY, ACCUM, HOLD.
  - **EMPTY + S2 beat:** `acc = sext(partial)`, `acc_exp = e_b`. Go to HOLD if last, else ACCUM.
  - **ACCUM + S2 beat, case `e_b > acc_exp`:** arithmetic-shift `acc` right by `e_b−acc_exp`, then set `acc_exp = e_b`.
  - **ACCUM + S2 beat, other case:** arithmetic-shift the partial right by `acc_exp−e_b`.
  - **ACCUM + S2 beat, both cases:** a shift ≥ accWidth yields sign fill. Add; go to HOLD if last.
  - **Saturation:** sum clamps to [−2^(accWidth−1), 2^(accWidth−1)−1]. Saturation is sticky until the result is emitted.
  - **HOLD:** `out_valid = 1`; `acc_man` and `acc_exp` are stable. On `out_ready`, go to EMPTY, or take the S2 beat as a fresh first beat in the same cycle.
- **Stall:** `stall = out_valid & ~out_ready`.
  - `in_ready = ~stall & ~rst`.
  - S1, S2 and S3 all freeze on stall. No beat is lost or duplicated.
- **Reset:**
  - Valids clear and the FSM goes to EMPTY.
  - `acc_man`, `acc_exp` and internal registers go to 0.
  - `out_valid` = 0, `in_ready` = 0 during reset.
  - In-flight beats are discarded.

## Timing
- Accepted at edge t: S1 at t+1, S2 at t+2, accumulator at t+3.
- A last beat accepted at t gives `out_valid` high from cycle t+3. Latency is 3.
- Throughput is one beat per cycle when not stalled; a one-beat dot product can complete every cycle.
- `in_ready` is combinational from `out_valid`/`out_ready`. `out_valid`, `acc_man` and `acc_exp` are registered.

## Configuration
- `ALIGN_STICKY_EN`:
  - Defined: S1 ORs all bits shifted out of `mag` into its LSB (sticky) before negation. For offset ≥ AW, `mag = (man≠0)`.
  - Undefined: plain truncation.
- Accumulator shifts always truncate in either configuration.

## Structure
- **Shared package `gemm_pkg`:**
  - `LANES = 4`.
  - `GUARD_BITS_DEF = 3`.
  - FSM enum `acc_state_t {ACC_EMPTY, ACC_ACCUM, ACC_HOLD}`.
- **Sub-module `lane_aligner`:** one lane's shift, sticky and negation; instantiated 4×.

## Test plan
- **Single beat:** 4 lanes `man=4'b1000`, sign 0, `max_exp=3`, offsets 0, last → `acc_man=256`, `acc_exp=3`, `out_valid` at cycle t+3.
- **Offsets and sticky:** lane0 `4'b1111` offset 7, lanes 1–3 zero.
  - Without `ALIGN_STICKY_EN`: `acc_man=0`.
  - With `ALIGN_STICKY_EN`: `acc_man=1`.
  - Check also: lane `4'b1000` offset 1 alone → 32.
- **Exponent realign:** beat A `max_exp=2`, partial 256; beat B `max_exp=4`, partial 256, last → `acc_man=320`, `acc_exp=4`.
- **Backpressure:** hold `out_ready=0` 5 cycles with `in_valid` high.
  - `in_ready=0` and outputs stable throughout.
  - On release, the next result arrives intact with no dropped beat.
- **Saturation:** 200 beats of 4 lanes −1.0 (`man=4'b1000`, sign 1), equal exponents → `acc_man=−32768`. The following dot product starts clean.
- **Reset mid-op:** assert `rst` for 1 cycle after 2 of 3 beats.
  - All outputs go to 0, `out_valid=0`.
  - A new single-beat dot product then yields the expected 256.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared definitions for the GEMM datapath blocks.
// Provides the lane count, the default guard-bit count and the accumulator
// FSM state encoding used by mant_align_acc.
package gemm_pkg;
  localparam int LANES          = 4;
  localparam int GUARD_BITS_DEF = 3;

  typedef enum logic [1:0] {
    ACC_EMPTY,
    ACC_ACCUM,
    ACC_HOLD
  } acc_state_t;
endpackage

// File: rtl/lane_aligner.sv
// lane_aligner: one lane of the S1 alignment stage (purely combinational).
// Appends guard bits to the mantissa, right-shifts it by the lane offset and
// applies the sign as a two's-complement negation.
// Build option: ALIGN_STICKY_EN -- when defined, bits shifted out are ORed
// into the LSB of the magnitude before negation; otherwise plain truncation.
// Ports:
//   i_sign  lane sign (1 = negative)
//   i_man   lane mantissa, hidden bit at MSB
//   i_off   right-shift amount toward the shared exponent
//   o_lane  signed aligned lane, manWidth+guardBits+1 bits
module lane_aligner #(
  parameter int expWidth  = 3,
  parameter int manWidth  = 4,
  parameter int guardBits = 3
) (
  input  logic                          i_sign,
  input  logic [manWidth-1:0]           i_man,
  input  logic [expWidth-1:0]           i_off,
  output logic [manWidth+guardBits:0]   o_lane
);
  localparam int AW = manWidth + guardBits;

  logic [AW-1:0] w_ext;
  logic [AW-1:0] w_shr;
  logic [AW-1:0] w_mag;
  logic          w_big;

  assign w_ext = {i_man, {guardBits{1'b0}}};
  assign w_big = (32'(i_off) >= AW);
  assign w_shr = w_big ? '0 : (w_ext >> i_off);

`ifdef ALIGN_STICKY_EN
  logic [AW-1:0] w_mask;
  logic          w_lost;
  // Mask of the bits that fall off the bottom; all of them when fully shifted out.
  assign w_mask = w_big ? '1 : ~({AW{1'b1}} << i_off);
  assign w_lost = |(w_ext & w_mask);
  assign w_mag  = {w_shr[AW-1:1], w_shr[0] | w_lost};
`else
  assign w_mag  = w_shr;
`endif

  assign o_lane = i_sign ? -{1'b0, w_mag} : {1'b0, w_mag};
endmodule

// File: rtl/mant_align_acc.sv
// mant_align_acc: block-floating-point mantissa aligner and accumulator.
// S1 aligns four sign/mantissa lanes to the beat's shared exponent, S2 sums
// them into a signed partial, S3 accumulates partials across beats (with
// exponent realignment and sticky saturation) until the last beat, then holds
// {acc_man, acc_exp} on a valid/ready handshake.
// Build option: ALIGN_STICKY_EN (see lane_aligner) selects sticky alignment.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input beat handshake; in_last marks final beat
//   in_sign, in_man          per-lane sign and mantissa (lane i at slice i)
//   max_exp, exp_offset_num  beat exponent and per-lane right-shift
//   out_valid/out_ready      result handshake
//   acc_man, acc_exp         signed accumulated mantissa and its exponent
module mant_align_acc
  import gemm_pkg::*;
#(
  parameter int expWidth  = 3,
  parameter int manWidth  = 4,
  parameter int guardBits = GUARD_BITS_DEF,
  parameter int accWidth  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [LANES-1:0]           in_sign,
  input  logic [LANES*manWidth-1:0]  in_man,
  input  logic [expWidth-1:0]        max_exp,
  input  logic [LANES*expWidth-1:0]  exp_offset_num,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [accWidth-1:0]        acc_man,
  output logic [expWidth-1:0]        acc_exp
);
  localparam int AW     = manWidth + guardBits;
  localparam int PW     = AW + 3;
  localparam int STAGES = 2;
  localparam logic [accWidth-1:0] ACC_MAX = {1'b0, {(accWidth-1){1'b1}}};
  localparam logic [accWidth-1:0] ACC_MIN = {1'b1, {(accWidth-1){1'b0}}};

  // Arithmetic right shift; shifts past the width leave only sign fill.
  function automatic logic [accWidth-1:0] asr(input logic signed [accWidth-1:0] x,
                                              input logic [expWidth-1:0] amt);
    if (32'(amt) >= accWidth) return {accWidth{x[accWidth-1]}};
    return x >>> amt;
  endfunction

  logic w_stall, w_take;
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall & ~rst;
  assign w_take   = in_valid & in_ready;

  // S1: per-lane alignment
  logic [LANES-1:0][AW:0] w_lane;
  logic [LANES-1:0][AW:0] r_s1_lane;
  logic [expWidth-1:0]    r_s1_exp;
  logic                   r_s1_last;
  logic [STAGES:1]        r_vld_pipe;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_aligner #(
      .expWidth (expWidth),
      .manWidth (manWidth),
      .guardBits(guardBits)
    ) u_lane (
      .i_sign(in_sign[i]),
      .i_man (in_man[i*manWidth +: manWidth]),
      .i_off (exp_offset_num[i*expWidth +: expWidth]),
      .o_lane(w_lane[i])
    );
  end

  // S2: four-lane sum
  logic [PW-1:0]        w_part;
  logic signed [PW-1:0] r_s2_part;
  logic [expWidth-1:0]  r_s2_exp;
  logic                 r_s2_last;

  always_comb begin
    w_part = '0;
    for (int i = 0; i < LANES; i++)
      w_part = w_part + {{2{r_s1_lane[i][AW]}}, r_s1_lane[i]};
  end

  // S3: accumulate
  acc_state_t                  r_state;
  logic signed [accWidth-1:0]  r_acc;
  logic [expWidth-1:0]         r_acc_exp;
  logic                        r_sat;
  logic                        r_out_valid;

  logic signed [accWidth-1:0]  w_part_x;
  logic [accWidth-1:0]         w_acc_sh, w_add_b, w_acc_nxt;
  logic [accWidth:0]           w_sum;
  logic [expWidth-1:0]         w_new_exp;
  logic                        w_up, w_ovf_hi, w_ovf_lo;

  assign w_part_x = r_s2_part;

  always_comb begin
    w_up      = r_s2_exp > r_acc_exp;
    // Whichever operand carries the smaller exponent is shifted down to the larger one.
    w_acc_sh  = w_up ? asr(r_acc, r_s2_exp - r_acc_exp) : r_acc;
    w_add_b   = w_up ? w_part_x : asr(w_part_x, r_acc_exp - r_s2_exp);
    w_new_exp = w_up ? r_s2_exp : r_acc_exp;
    w_sum     = {w_acc_sh[accWidth-1], w_acc_sh} + {w_add_b[accWidth-1], w_add_b};
    w_ovf_hi  = ~w_sum[accWidth] &  w_sum[accWidth-1];
    w_ovf_lo  =  w_sum[accWidth] & ~w_sum[accWidth-1];
    w_acc_nxt = w_ovf_hi ? ACC_MAX : (w_ovf_lo ? ACC_MIN : w_sum[accWidth-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_s1_lane   <= '0;
      r_s1_exp    <= '0;
      r_s1_last   <= 1'b0;
      r_s2_part   <= '0;
      r_s2_exp    <= '0;
      r_s2_last   <= 1'b0;
      r_state     <= ACC_EMPTY;
      r_acc       <= '0;
      r_acc_exp   <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_take};
      r_s1_lane  <= w_lane;
      r_s1_exp   <= max_exp;
      r_s1_last  <= in_last;
      r_s2_part  <= w_part;
      r_s2_exp   <= r_s1_exp;
      r_s2_last  <= r_s1_last;
      case (r_state)
        // Not stalled in HOLD means the result is being taken this cycle,
        // so HOLD behaves like EMPTY and can start the next product at once.
        ACC_EMPTY, ACC_HOLD: begin
          if (r_vld_pipe[STAGES]) begin
            r_acc       <= w_part_x;
            r_acc_exp   <= r_s2_exp;
            r_sat       <= 1'b0;
            r_state     <= r_s2_last ? ACC_HOLD : ACC_ACCUM;
            r_out_valid <= r_s2_last;
          end else begin
            r_state     <= ACC_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ACC_ACCUM: begin
          if (r_vld_pipe[STAGES]) begin
            // Once clamped, the accumulator stays pinned until it is emitted.
            if (!r_sat) begin
              r_acc     <= w_acc_nxt;
              r_acc_exp <= w_new_exp;
              r_sat     <= w_ovf_hi | w_ovf_lo;
            end
            if (r_s2_last) begin
              r_state     <= ACC_HOLD;
              r_out_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= ACC_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign acc_man   = r_acc;
  assign acc_exp   = r_acc_exp;
endmodule
